// File: rtl/is_last_batch_pkg.sv
// is_last_batch_pkg
// Shared types for the is_last batch collector:
//   - state_t        : collector FSM states (COLLECT, EMIT)
//   - batch_record_t : one per-batch summary record at the default widths
//   - *_WIDTH_DEF    : default widths that batch_record_t is built from
package is_last_batch_pkg;

  localparam int DATA_WIDTH_DEF  = 32;
  localparam int COUNT_WIDTH_DEF = 16;
  localparam int SUM_WIDTH_DEF   = 48;
  localparam int INDEX_WIDTH_DEF = 16;

  typedef enum logic {
    COLLECT = 1'b0,
    EMIT    = 1'b1
  } state_t;

  typedef struct packed {
    logic [COUNT_WIDTH_DEF-1:0] count;
    logic [SUM_WIDTH_DEF-1:0]   sum;
    logic [DATA_WIDTH_DEF-1:0]  first;
    logic [DATA_WIDTH_DEF-1:0]  last;
    logic [INDEX_WIDTH_DEF-1:0] index;
    logic                       overflow;
  } batch_record_t;

endpackage

// File: rtl/is_last_batch_accum.sv
// is_last_batch_accum
// Per-batch datapath: element count (saturating), payload sum (wrapping),
// first payload and sticky overflow flag.
// Ports:
//   clk, rst            : clock, synchronous active-low reset
//   absorb_in           : a FIFO entry is popped this cycle
//   clear_in            : batch ends this cycle; registers return to zero
//   data_in             : payload of the popped entry
//   count_next_out ...  : batch values including the entry being absorbed,
//                         used by the top to latch the completed record
module is_last_batch_accum
  import is_last_batch_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int COUNT_WIDTH = 16,
  parameter int SUM_WIDTH   = 48
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   absorb_in,
  input  logic                   clear_in,
  input  logic [DATA_WIDTH-1:0]  data_in,
  output logic [COUNT_WIDTH-1:0] count_next_out,
  output logic [SUM_WIDTH-1:0]   sum_next_out,
  output logic [DATA_WIDTH-1:0]  first_next_out,
  output logic                   overflow_next_out
);

  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = {COUNT_WIDTH{1'b1}};

  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic [SUM_WIDTH-1:0]   sum_q, sum_d;
  logic [DATA_WIDTH-1:0]  first_q, first_d;
  logic                   overflow_q, overflow_d;
  logic                   at_max;

  // Values the batch would hold after absorbing data_in.
  always_comb begin
    at_max            = (count_q == COUNT_MAX);
    count_next_out    = at_max ? count_q : count_q + COUNT_WIDTH'(1);
    // The pop arriving while already at the maximum is the one that would
    // exceed it, so it raises the sticky overflow.
    overflow_next_out = overflow_q | at_max;
    sum_next_out      = sum_q + {{(SUM_WIDTH-DATA_WIDTH){1'b0}}, data_in};
    first_next_out    = (count_q == '0) ? data_in : first_q;
  end

  // Clear wins over absorb: the is_last pop is absorbed into the record
  // latched by the top, not into the next batch.
  always_comb begin
    count_d    = count_q;
    sum_d      = sum_q;
    first_d    = first_q;
    overflow_d = overflow_q;
    if (clear_in) begin
      count_d    = '0;
      sum_d      = '0;
      first_d    = '0;
      overflow_d = 1'b0;
    end else if (absorb_in) begin
      count_d    = count_next_out;
      sum_d      = sum_next_out;
      first_d    = first_next_out;
      overflow_d = overflow_next_out;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q    <= '0;
      sum_q      <= '0;
      first_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      sum_q      <= sum_d;
      first_q    <= first_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: rtl/is_last_batch_collector.sv
// is_last_batch_collector
// Drains a show-ahead callback FIFO one entry per cycle, groups entries into
// batches terminated by is_last, and presents one summary record per batch
// over a ready/valid interface.
// Ports:
//   clk, rst           : clock, synchronous active-low reset
//   cb_rden_out        : pop request to the callback FIFO
//   cb_empty_in        : FIFO empty
//   cb_a_in            : head-entry payload
//   cb_is_last_in      : head entry closes its batch
//   rec_valid_out      : summary record valid
//   rec_ready_in       : consumer accepts the record
//   rec_count_out      : elements in the batch (saturating)
//   rec_sum_out        : payload sum modulo 2^SUM_WIDTH
//   rec_first_out      : first payload of the batch
//   rec_last_out       : payload of the is_last entry
//   rec_index_out      : batch sequence number from 0
//   rec_overflow_out   : count saturated in this batch
module is_last_batch_collector
  import is_last_batch_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int COUNT_WIDTH = 16,
  parameter int SUM_WIDTH   = 48,
  parameter int INDEX_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   cb_rden_out,
  input  logic                   cb_empty_in,
  input  logic [DATA_WIDTH-1:0]  cb_a_in,
  input  logic                   cb_is_last_in,
  output logic                   rec_valid_out,
  input  logic                   rec_ready_in,
  output logic [COUNT_WIDTH-1:0] rec_count_out,
  output logic [SUM_WIDTH-1:0]   rec_sum_out,
  output logic [DATA_WIDTH-1:0]  rec_first_out,
  output logic [DATA_WIDTH-1:0]  rec_last_out,
  output logic [INDEX_WIDTH-1:0] rec_index_out,
  output logic                   rec_overflow_out
);

  state_t                 state_q, state_d;
  logic [INDEX_WIDTH-1:0] index_q, index_d;

  logic [COUNT_WIDTH-1:0] rec_count_q, rec_count_d;
  logic [SUM_WIDTH-1:0]   rec_sum_q, rec_sum_d;
  logic [DATA_WIDTH-1:0]  rec_first_q, rec_first_d;
  logic [DATA_WIDTH-1:0]  rec_last_q, rec_last_d;
  logic [INDEX_WIDTH-1:0] rec_index_q, rec_index_d;
  logic                   rec_overflow_q, rec_overflow_d;

  logic                   pop;
  logic                   batch_end;
  logic [COUNT_WIDTH-1:0] acc_count;
  logic [SUM_WIDTH-1:0]   acc_sum;
  logic [DATA_WIDTH-1:0]  acc_first;
  logic                   acc_overflow;

  // rst is part of the pop term so the FIFO is never drained while the
  // collector is being held in reset.
  always_comb begin
    pop       = rst && (state_q == COLLECT) && !cb_empty_in;
    batch_end = pop && cb_is_last_in;
  end

  is_last_batch_accum #(
    .DATA_WIDTH (DATA_WIDTH),
    .COUNT_WIDTH(COUNT_WIDTH),
    .SUM_WIDTH  (SUM_WIDTH)
  ) u_accum (
    .clk              (clk),
    .rst              (rst),
    .absorb_in        (pop),
    .clear_in         (batch_end),
    .data_in          (cb_a_in),
    .count_next_out   (acc_count),
    .sum_next_out     (acc_sum),
    .first_next_out   (acc_first),
    .overflow_next_out(acc_overflow)
  );

  // The record register is loaded only on the is_last pop, so it stays
  // stable for the whole EMIT wait regardless of what the FIFO presents.
  always_comb begin
    state_d        = state_q;
    index_d        = index_q;
    rec_count_d    = rec_count_q;
    rec_sum_d      = rec_sum_q;
    rec_first_d    = rec_first_q;
    rec_last_d     = rec_last_q;
    rec_index_d    = rec_index_q;
    rec_overflow_d = rec_overflow_q;
    case (state_q)
      COLLECT: begin
        if (batch_end) begin
          rec_count_d    = acc_count;
          rec_sum_d      = acc_sum;
          rec_first_d    = acc_first;
          rec_last_d     = cb_a_in;
          rec_index_d    = index_q;
          rec_overflow_d = acc_overflow;
          state_d        = EMIT;
        end
      end
      EMIT: begin
        if (rec_ready_in) begin
          index_d = index_q + INDEX_WIDTH'(1);
          state_d = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= COLLECT;
      index_q        <= '0;
      rec_count_q    <= '0;
      rec_sum_q      <= '0;
      rec_first_q    <= '0;
      rec_last_q     <= '0;
      rec_index_q    <= '0;
      rec_overflow_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      index_q        <= index_d;
      rec_count_q    <= rec_count_d;
      rec_sum_q      <= rec_sum_d;
      rec_first_q    <= rec_first_d;
      rec_last_q     <= rec_last_d;
      rec_index_q    <= rec_index_d;
      rec_overflow_q <= rec_overflow_d;
    end
  end

  always_comb begin
    cb_rden_out      = pop;
    rec_valid_out    = (state_q == EMIT);
    rec_count_out    = rec_count_q;
    rec_sum_out      = rec_sum_q;
    rec_first_out    = rec_first_q;
    rec_last_out     = rec_last_q;
    rec_index_out    = rec_index_q;
    rec_overflow_out = rec_overflow_q;
  end

endmodule
